// File: rtl/hazard_stall_ctrl.sv
// Decode-stage hazard controller: stall, EX bubble and forwarding selects.
// Optional feature macro: FORWARDING_EN (load-use-only stalls plus selects).
module hazard_stall_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        id_valid,
  input  logic [2:0]  id_rs,
  input  logic [2:0]  id_rt,
  input  logic        id_rs_used,
  input  logic        id_rt_used,
  input  logic [2:0]  id_rd,
  input  logic        id_writes,
  input  logic        id_is_load,
  input  logic        flush,
  output logic        stall,
  output logic        ex_bubble,
  output logic [1:0]  ex_fwd_a,
  output logic [1:0]  ex_fwd_b,
  output logic [15:0] stall_count
);

  typedef struct packed {
    logic       v;
    logic [2:0] rd;
    logic       ld;
  } slot_t;

  slot_t ex_q, mem_q, wb_q;

  logic rs_ex, rt_ex, rs_mem, rt_mem;
  logic advance;
  logic [1:0] fwd_a_d, fwd_b_d;

  assign rs_ex  = id_rs_used && ex_q.v  && (id_rs == ex_q.rd);
  assign rt_ex  = id_rt_used && ex_q.v  && (id_rt == ex_q.rd);
  assign rs_mem = id_rs_used && mem_q.v && (id_rs == mem_q.rd);
  assign rt_mem = id_rt_used && mem_q.v && (id_rt == mem_q.rd);

`ifdef FORWARDING_EN
  // A load in EX has no data yet; every other match is forwarded.
  assign stall = id_valid && !flush && ex_q.ld && (rs_ex || rt_ex);

  assign fwd_a_d = rs_ex ? 2'b01 : (rs_mem ? 2'b10 : 2'b00);
  assign fwd_b_d = rt_ex ? 2'b01 : (rt_mem ? 2'b10 : 2'b00);

  logic unused_slot_bits;
  assign unused_slot_bits = ^{wb_q, mem_q.ld};
`else
  assign stall = id_valid && !flush &&
                 (rs_ex || rt_ex || rs_mem || rt_mem);

  assign fwd_a_d = 2'b00;
  assign fwd_b_d = 2'b00;

  logic unused_slot_bits;
  assign unused_slot_bits = ^{wb_q, ex_q.ld, mem_q.ld};
`endif

  assign advance = id_valid && !stall && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q        <= '0;
      mem_q       <= '0;
      wb_q        <= '0;
      ex_bubble   <= 1'b1;
      ex_fwd_a    <= 2'b00;
      ex_fwd_b    <= 2'b00;
      stall_count <= 16'h0000;
    end else begin
      wb_q  <= mem_q;
      mem_q <= ex_q;
      if (advance) begin
        ex_q      <= '{v: id_writes, rd: id_rd, ld: id_is_load};
        ex_bubble <= 1'b0;
        ex_fwd_a  <= fwd_a_d;
        ex_fwd_b  <= fwd_b_d;
      end else begin
        ex_q      <= '0;
        ex_bubble <= 1'b1;
        ex_fwd_a  <= 2'b00;
        ex_fwd_b  <= 2'b00;
      end
      if (stall && stall_count != 16'hFFFF)
        stall_count <= stall_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Bench for hazard_stall_ctrl: directed scenarios plus random traffic
// checked against a producer-distance reference model.
module tb_hazard_stall_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid;
  logic [2:0]  id_rs, id_rt, id_rd;
  logic        id_rs_used, id_rt_used;
  logic        id_writes, id_is_load, flush;
  logic        stall, ex_bubble;
  logic [1:0]  ex_fwd_a, ex_fwd_b;
  logic [15:0] stall_count;

  hazard_stall_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .id_valid    (id_valid),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_rs_used  (id_rs_used),
    .id_rt_used  (id_rt_used),
    .id_rd       (id_rd),
    .id_writes   (id_writes),
    .id_is_load  (id_is_load),
    .flush       (flush),
    .stall       (stall),
    .ex_bubble   (ex_bubble),
    .ex_fwd_a    (ex_fwd_a),
    .ex_fwd_b    (ex_fwd_b),
    .stall_count (stall_count)
  );

  always #5 clk = ~clk;

`ifdef FORWARDING_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  int errs = 0;
  int total = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Producers by distance from decode: 1 = one ahead, 2 = two ahead.
  logic       pv  [1:2];
  logic [2:0] prd [1:2];
  logic       pld [1:2];
  logic       m_bub;
  logic [1:0] m_fa, m_fb;
  int         m_cnt;

  function automatic void m_reset();
    for (int d = 1; d <= 2; d++) begin
      pv[d] = 1'b0; prd[d] = 3'd0; pld[d] = 1'b0;
    end
    m_bub = 1'b1; m_fa = 2'b00; m_fb = 2'b00; m_cnt = 0;
  endfunction

  function automatic logic needs(int d, logic [2:0] s, logic u);
    return u && pv[d] && (prd[d] == s);
  endfunction

  function automatic logic m_stall();
    logic dep1, dep2;
    dep1 = needs(1, id_rs, id_rs_used) || needs(1, id_rt, id_rt_used);
    dep2 = needs(2, id_rs, id_rs_used) || needs(2, id_rt, id_rt_used);
    if (!id_valid || flush) return 1'b0;
    if (FWD) return dep1 && pld[1];
    return dep1 || dep2;
  endfunction

  function automatic logic [1:0] m_sel(logic [2:0] s, logic u);
    if (!FWD) return 2'b00;
    if (needs(1, s, u)) return 2'b01;
    if (needs(2, s, u)) return 2'b10;
    return 2'b00;
  endfunction

  // One decode cycle; starts and ends just after a falling edge.
  task automatic cyc(input logic v, input logic [2:0] rs, input logic ru,
                     input logic [2:0] rt, input logic tu,
                     input logic [2:0] rd, input logic w, input logic ld,
                     input logic fl, output logic adv);
    logic es;
    id_valid = v; id_rs = rs; id_rs_used = ru; id_rt = rt;
    id_rt_used = tu; id_rd = rd; id_writes = w; id_is_load = ld;
    flush = fl;
    #1;
    es = m_stall();
    check("stall", stall, es);
    adv = v && !es && !fl;
    @(posedge clk);
    if (adv) begin
      m_fa = m_sel(rs, ru);
      m_fb = m_sel(rt, tu);
    end else begin
      m_fa = 2'b00; m_fb = 2'b00;
    end
    pv[2] = pv[1]; prd[2] = prd[1]; pld[2] = pld[1];
    pv[1] = adv && w; prd[1] = rd; pld[1] = adv && ld;
    m_bub = !adv;
    if (es && m_cnt < 65535) m_cnt++;
    #1;
    check("ex_bubble", ex_bubble, m_bub);
    check("ex_fwd_a", ex_fwd_a, m_fa);
    check("ex_fwd_b", ex_fwd_b, m_fb);
    check("stall_count", stall_count, m_cnt);
    @(negedge clk);
  endtask

  // Hold one instruction in decode until it advances; returns stall cycles.
  task automatic issue(input logic [2:0] rs, input logic ru,
                       input logic [2:0] rt, input logic tu,
                       input logic [2:0] rd, input logic w, input logic ld,
                       output int stalls);
    logic adv;
    stalls = 0;
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, rs, ru, rt, tu, rd, w, ld, 1'b0, adv);
      if (adv) return;
      stalls++;
    end
    check("issue_timeout", 32'd1, 32'd0);
  endtask

  task automatic idle(input int n);
    logic adv;
    for (int i = 0; i < n; i++)
      cyc(1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, adv);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    m_reset();
    check("rst_stall", stall, 1'b0);
    check("rst_bubble", ex_bubble, 1'b1);
    check("rst_fwd_a", ex_fwd_a, 2'b00);
    check("rst_fwd_b", ex_fwd_b, 2'b00);
    check("rst_count", stall_count, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int st;
    int c0;
    logic adv;
    id_valid = 0; id_rs = 0; id_rt = 0; id_rs_used = 0; id_rt_used = 0;
    id_rd = 0; id_writes = 0; id_is_load = 0; flush = 0;
    m_reset();
    @(negedge clk);
    do_reset();
    idle(3);

    // Back-to-back dependent ALU ops: r3 <- r1,r2 ; r4 <- r3,r5
    issue(3'd1, 1'b1, 3'd2, 1'b1, 3'd3, 1'b1, 1'b0, st);
    check("alu_prod_stalls", st, 0);
    c0 = m_cnt;
    issue(3'd3, 1'b1, 3'd5, 1'b1, 3'd4, 1'b1, 1'b0, st);
    check("alu_dep_stalls", st, FWD ? 0 : 2);
    check("alu_dep_count", stall_count - c0[15:0], FWD ? 0 : 2);
    check("alu_dep_fwd_a", ex_fwd_a, FWD ? 2'b01 : 2'b00);
    check("alu_dep_fwd_b", ex_fwd_b, 2'b00);
    idle(3);

    // Load-use: LD r2 ; r6 <- r1,r2
    issue(3'd0, 1'b1, 3'd0, 1'b0, 3'd2, 1'b1, 1'b1, st);
    issue(3'd1, 1'b1, 3'd2, 1'b1, 3'd6, 1'b1, 1'b0, st);
    check("ld_use_stalls", st, FWD ? 1 : 2);
    check("ld_use_fwd_b", ex_fwd_b, FWD ? 2'b10 : 2'b00);
    idle(3);

    // One intervening instruction
    issue(3'd1, 1'b1, 3'd1, 1'b0, 3'd7, 1'b1, 1'b0, st);
    issue(3'd0, 1'b1, 3'd0, 1'b0, 3'd5, 1'b1, 1'b0, st);
    issue(3'd7, 1'b1, 3'd0, 1'b0, 3'd6, 1'b1, 1'b0, st);
    check("gap1_stalls", st, FWD ? 0 : 1);
    check("gap1_fwd_a", ex_fwd_a, FWD ? 2'b10 : 2'b00);
    idle(3);

    // Non-writing producer never causes a hazard
    issue(3'd1, 1'b1, 3'd0, 1'b0, 3'd4, 1'b0, 1'b1, st);
    issue(3'd4, 1'b1, 3'd4, 1'b1, 3'd2, 1'b1, 1'b0, st);
    check("nowrite_stalls", st, 0);
    idle(3);

    // Flush during a pending load-use hazard
    issue(3'd0, 1'b0, 3'd0, 1'b0, 3'd3, 1'b1, 1'b1, st);
    c0 = m_cnt;
    cyc(1'b1, 3'd3, 1'b1, 3'd0, 1'b0, 3'd4, 1'b1, 1'b0, 1'b1, adv);
    check("flush_bubble", ex_bubble, 1'b1);
    check("flush_count", stall_count, c0[15:0]);
    idle(3);

    // Reset in the middle of a stall
    issue(3'd0, 1'b0, 3'd0, 1'b0, 3'd5, 1'b1, 1'b1, st);
    id_valid = 1; id_rs = 3'd5; id_rs_used = 1; id_rt_used = 0;
    id_rd = 3'd1; id_writes = 1; id_is_load = 0; flush = 0;
    #1;
    check("pre_rst_stall", stall, 1'b1);
    do_reset();
    issue(3'd5, 1'b1, 3'd0, 1'b0, 3'd1, 1'b1, 1'b0, st);
    check("post_rst_stalls", st, 0);

    // Random traffic over a small register file
    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(0, 9) < 8, 3'($urandom), 1'($urandom),
          3'($urandom), 1'($urandom), 3'($urandom),
          $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
          $urandom_range(0, 9) == 0, adv);
    end

    $display("Result: errors=%0d of %0d checks", errs, total);
    $finish;
  end

endmodule

// File: doc/hazard_stall_ctrl.md
# hazard_stall_ctrl

Decode-stage hazard controller for the 5-stage pipeline. Tracks the destination register specifiers of in-flight instructions (EX, MEM, WB) and compares each decode-stage source specifier against them with 3-bit equality matches. On a dependency it stalls fetch/decode and inserts a bubble into EX; when forwarding is compiled in, it also registers per-operand forwarding selects for the EX stage. It is the consumer end of the register-specifier compare path: it decides what to do with each match.

## Interface
- No parameters. Register specifier width is fixed at 3 bits (8 GPRs, all writeable).
- clk  in  1  pipeline clock
- rst_n  in  1  asynchronous, active-low reset
- id_valid  in  1  decode stage holds a valid instruction
- id_rs, id_rt  in  3 each  decode source specifiers
- id_rs_used, id_rt_used  in  1 each  source actually read
- id_rd  in  3  decode destination specifier
- id_writes  in  1  instruction writes id_rd
- id_is_load  in  1  instruction is a load
- flush  in  1  squash the decode instruction (branch redirect)
- stall  out  1  hold PC and IF/ID; combinational
- ex_bubble  out  1  registered; EX slot holds a bubble this cycle
- ex_fwd_a, ex_fwd_b  out  2 each  registered EX operand selects: 00 regfile, 01 EX/MEM, 10 MEM/WB
- stall_count  out  16  saturating count of stalled cycles

## Operation
- Tracking slots EX, MEM, WB each hold {v, rd[2:0], ld}. Every clock: WB <= MEM, MEM <= EX.
- EX load: if id_valid && !stall && !flush, EX <= {id_writes, id_rd, id_is_load}; otherwise EX <= {0, 000, 0} and ex_bubble <= 1.
- Match: src_hit_X = src_used && slot_X.v && (src == slot_X.rd), for src in {rs, rt}, X in {EX, MEM}. WB hits are ignored; the register file writes before reads.
- Without forwarding: stall = id_valid && !flush && (any hit in EX or MEM).
- With forwarding: stall = id_valid && !flush && (any hit in EX where EX.ld == 1). This covers load-use only.
- Forward selects, registered when the instruction advances into EX:
  - EX hit (non-load) -> 01.
  - MEM hit -> 10.
  - If both hit, EX has priority (younger producer).
  - No hit, a bubble, or forwarding compiled out -> 00.
- flush has priority over stall: stall = 0 and EX gets a bubble.
- stall_count increments on every cycle with stall = 1 and saturates at 16'hFFFF.

## Timing
- Reset (rst_n low, asynchronous): all slots invalid, ex_bubble = 1, ex_fwd_a = ex_fwd_b = 00, stall_count = 0.
- stall is combinational from ID inputs and slot state in the same cycle.
- All other outputs update one clock after the cause.
- Back-to-back dependent ALU ops:
  - Without forwarding: 2 stall cycles. The first with the producer in EX, the second with the producer in MEM.
  - With forwarding: 0 stall cycles.
- Load followed by a dependent instruction with forwarding: 1 stall cycle. The consumer then enters EX with select 10.
- One intervening instruction between producer and consumer:
  - Without forwarding: 1 stall cycle.
  - With forwarding: 0 stall cycles, select 10.
- Reset asserted mid-stall clears the stall on the next evaluation, because all slots become invalid.
- An instruction with id_writes = 0 never causes a hazard, whatever id_rd holds.

## Configuration
- FORWARDING_EN defined: load-use-only stalls; ex_fwd_a/ex_fwd_b are driven as specified.
- FORWARDING_EN undefined: stall on any EX or MEM dependency; ex_fwd_a/ex_fwd_b are tied to 00.

## Test plan
- Reset, then id_valid = 0 for 3 cycles -> stall = 0, ex_bubble = 1, stall_count = 0.
- FORWARDING_EN off: ADD r3 <- r1,r2 then ADD r4 <- r3,r5 -> stall high for exactly 2 cycles, stall_count = 2, then the consumer enters EX with ex_fwd_a = 00.
- FORWARDING_EN on: same pair -> no stall; on the consumer's EX cycle, ex_fwd_a = 01 and ex_fwd_b = 00.
- FORWARDING_EN on: LD r2, then ADD r6 <- r1,r2 -> 1 stall cycle, one bubble in EX, then ex_fwd_b = 10.
- flush asserted while a hazard is pending -> stall = 0 in that cycle, ex_bubble = 1 next cycle, stall_count unchanged.
- rst_n pulsed low while stall = 1 -> outputs immediately return to reset values; the next decode of the dependent instruction shows no stall.
